seq_detector: RTL

Serial bit-stream pattern detector placed directly downstream of the team's registered 1-bit D flip-flop stage. It consumes the registered bit `o_q` as `i_d`, qualified by `i_valid`. It flags every occurrence of a parameterised bit pattern and keeps a saturating count of matches. Overlapping and non-overlapping detection are both supported, so the block serves as the first protocol-level consumer of the flop-chain outputs.

---
 rtl/seq_detector_pkg.sv | 14 +
 rtl/seq_detector_if.sv | 30 +++
 rtl/seq_detector_sat_counter.sv | 23 ++
 rtl/seq_detector.sv | 77 +++++++
 4 files changed

// File: rtl/seq_detector_pkg.sv
// Shared types and defaults for the serial pattern detector.
// FSM state encoding lives here so the top and bench agree.
package seq_detector_pkg;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int          DEF_PATTERN_W = 4;
  localparam logic [15:0] DEF_PATTERN   = 16'h000B;
  localparam int          DEF_CNT_W     = 8;

endpackage

// File: rtl/seq_detector_if.sv
// Bit-stream input and detection result bundle.
// master drives the stream, slave is the detector.
interface seq_detector_if #(
  parameter int CNT_W = 8
);
  logic             i_d;
  logic             i_valid;
  logic             i_clr;
  logic             o_det;
  logic [CNT_W-1:0] o_det_cnt;
  logic             o_fill;

  modport master (
    output i_d,
    output i_valid,
    output i_clr,
    input  o_det,
    input  o_det_cnt,
    input  o_fill
  );

  modport slave (
    input  i_d,
    input  i_valid,
    input  i_clr,
    output o_det,
    output o_det_cnt,
    output o_fill
  );
endinterface

// File: rtl/seq_detector_sat_counter.sv
// Saturating match counter with synchronous clear.
// A clear coincident with an increment yields 1.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_cnt
);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_cnt <= '0;
    end else if (i_clr) begin
      o_cnt <= CNT_W'(i_inc);
    end else if (i_inc && (o_cnt != '1)) begin
      o_cnt <= o_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seq_detector.sv
// Serial pattern detector: shifts valid bits into a history
// register and pulses o_det when the last bits equal PATTERN.
module seq_detector
  import seq_detector_pkg::*;
#(
  parameter int                    PATTERN_W = DEF_PATTERN_W,
  parameter logic [PATTERN_W-1:0]  PATTERN   = PATTERN_W'(DEF_PATTERN),
  parameter int                    OVERLAP   = 1,
  parameter int                    CNT_W     = DEF_CNT_W
) (
  input  logic                i_clk,
  input  logic                i_rst,
  seq_detector_if.slave       bus
);

  localparam int FW = $clog2(PATTERN_W + 1);
  localparam logic [FW-1:0] FULL = FW'(PATTERN_W);

  state_t               state;
  logic [PATTERN_W-1:0] hist;
  logic [PATTERN_W-1:0] hist_nx;
  logic [FW-1:0]        fcnt;
  logic [FW-1:0]        fcnt_nx;
  logic                 match;

  always_comb begin
    hist_nx = (hist << 1) | PATTERN_W'(bus.i_d);
    fcnt_nx = (fcnt == FULL) ? fcnt : fcnt + FW'(1);
    match   = bus.i_valid
            && (hist_nx == PATTERN)
            && (fcnt_nx == FULL);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= ST_FILL;
      hist       <= '0;
      fcnt       <= '0;
      bus.o_det  <= 1'b0;
      bus.o_fill <= 1'b1;
    end else begin
      bus.o_det <= match;
      if (bus.i_valid) begin
        // non-overlapping mode restarts from an empty history
        if (match && (OVERLAP == 0)) begin
          state      <= ST_FILL;
          hist       <= '0;
          fcnt       <= '0;
          bus.o_fill <= 1'b1;
        end else begin
          hist <= hist_nx;
          fcnt <= fcnt_nx;
          unique case (state)
            ST_FILL: begin
              if (fcnt_nx == FULL) begin
                state      <= ST_RUN;
                bus.o_fill <= 1'b0;
              end
            end
            ST_RUN: ;
          endcase
        end
      end
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_inc(match),
    .i_clr(bus.i_clr),
    .o_cnt(bus.o_det_cnt)
  );

endmodule
